multi_cycle_ctrl: RTL and testbench

- Main sequencer for the multi-cycle CPU: one-hot IF/ID/EXE/MEM/WB stage enables plus PC, IR, data-memory and register-file write strobes.
- Stage count per instruction depends on the decoded instruction class, with stalls for multi-cycle EXE ops and slow data memory.
- Also provides debug halt/single-step, the display_state code, and cycle/retire counters for the board display and bench.

---
 rtl/multi_cycle_pkg.sv | 28 ++
 rtl/multi_cycle_ctrl_if.sv | 47 ++++
 rtl/multi_cycle_ctrl_counters.sv | 34 +++
 rtl/multi_cycle_ctrl.sv | 125 ++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state codes, display width
// and the instruction-class flags latched in ID.
package multi_cycle_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned DISP_W  = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef struct packed {
        logic rf_wen;
        logic mem_op;
        logic store;
    } iclass_t;

    // Zero-extended state code as shown on the board display.
    function automatic logic [DISP_W-1:0] display_code(input state_e s);
        return {{(DISP_W - STATE_W){1'b0}}, s};
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Handshake bundle between the sequencer (master) and the datapath/debug side (slave).
interface multi_cycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import multi_cycle_pkg::*;

    logic id_jbr;
    logic id_rf_wen;
    logic id_mem_op;
    logic id_store;
    logic exe_busy;
    logic mem_ready;
    logic halt_req;
    logic step;

    logic IF_valid;
    logic ID_valid;
    logic EXE_valid;
    logic MEM_valid;
    logic WB_valid;
    logic ir_we;
    logic pc_we;
    logic dm_we_en;
    logic rf_we_en;
    logic retire;
    logic halted;
    logic [DISP_W-1:0] display_state;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        input  id_jbr, id_rf_wen, id_mem_op, id_store,
        input  exe_busy, mem_ready, halt_req, step,
        output IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
        output ir_we, pc_we, dm_we_en, rf_we_en, retire, halted,
        output display_state, cycle_cnt, retire_cnt
    );

    modport slave (
        output id_jbr, id_rf_wen, id_mem_op, id_store,
        output exe_busy, mem_ready, halt_req, step,
        input  IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
        input  ir_we, pc_we, dm_we_en, rf_we_en, retire, halted,
        input  display_state, cycle_cnt, retire_cnt
    );

endinterface

// File: rtl/multi_cycle_ctrl_counters.sv
// Free-running cycle and retire counters; both wrap modulo 2^CNT_W.
module ctrl_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cyc_en,
    input  logic             ret_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q + CNT_W'(cyc_en);
        ret_d = ret_q + CNT_W'(ret_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_cnt  = cyc_q;
    assign retire_cnt = ret_q;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main sequencer of the multi-cycle CPU: walks IF/ID/EXE/MEM/WB per instruction class,
// stalls on busy EXE and slow memory, and supports debug halt/single-step.
module multi_cycle_ctrl
    import multi_cycle_pkg::*;
#(
    parameter bit          SKIP_MEM = 1'b0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    multi_cycle_ctrl_if.master bus
);

    state_e  state_q, state_d;
    iclass_t cls_q, cls_d;

    logic ir_we_c;
    logic dm_we_c;
    logic rf_we_c;
    logic retire_c;
    logic run_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IF;
            cls_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Next-state and strobe decode; strobes depend on the current state plus live stall inputs.
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        ir_we_c  = 1'b0;
        dm_we_c  = 1'b0;
        rf_we_c  = 1'b0;
        retire_c = 1'b0;

        unique case (state_q)
            ST_IF: begin
                ir_we_c = 1'b1;
                state_d = ST_ID;
            end
            ST_ID: begin
                cls_d = '{rf_wen: bus.id_rf_wen, mem_op: bus.id_mem_op, store: bus.id_store};
                if (bus.id_jbr && !bus.id_rf_wen) begin
                    retire_c = 1'b1;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                if (!bus.exe_busy) begin
                    if (cls_q.mem_op || (!SKIP_MEM && cls_q.rf_wen)) begin
                        state_d = ST_MEM;
                    end else if (cls_q.rf_wen) begin
                        state_d = ST_WB;
                    end else begin
                        retire_c = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                // Non-memory ops only pass through for the fixed 5-cycle timing.
                if (!cls_q.mem_op) begin
                    state_d = ST_WB;
                end else if (bus.mem_ready) begin
                    if (cls_q.store) begin
                        dm_we_c  = 1'b1;
                        retire_c = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we_c  = 1'b1;
                retire_c = 1'b1;
            end
            ST_HALT: begin
                if (!bus.halt_req || bus.step) begin
                    state_d = ST_IF;
                end
            end
            default: begin
                state_d = ST_IF;
            end
        endcase

        // A step releases HALT for one instruction; its retire re-checks halt_req.
        if (retire_c) begin
            state_d = bus.halt_req ? ST_HALT : ST_IF;
        end
    end

    assign run_c = !reset;

    assign bus.IF_valid      = run_c && (state_q == ST_IF);
    assign bus.ID_valid      = run_c && (state_q == ST_ID);
    assign bus.EXE_valid     = run_c && (state_q == ST_EXE);
    assign bus.MEM_valid     = run_c && (state_q == ST_MEM);
    assign bus.WB_valid      = run_c && (state_q == ST_WB);
    assign bus.ir_we         = run_c && ir_we_c;
    assign bus.pc_we         = run_c && retire_c;
    assign bus.retire        = run_c && retire_c;
    assign bus.dm_we_en      = run_c && dm_we_c;
    assign bus.rf_we_en      = run_c && rf_we_c;
    assign bus.halted        = run_c && (state_q == ST_HALT);
    assign bus.display_state = display_code(state_q);

    ctrl_counters #(
        .CNT_W (CNT_W)
    ) u_counters (
        .clk        (clk),
        .reset      (reset),
        .cyc_en     (state_q != ST_HALT),
        .ret_en     (retire_c),
        .cycle_cnt  (bus.cycle_cnt),
        .retire_cnt (bus.retire_cnt)
    );

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: each instruction's stage sequence is derived from its class
// and stall counts, then compared cycle by cycle with outputs, display code and counters.
module tb_multi_cycle_ctrl;
    import multi_cycle_pkg::*;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned VW    = 11;
    localparam int unsigned TW    = VW + DISP_W + 2 * CNT_W;
    localparam int          MAXC  = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multi_cycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multi_cycle_ctrl #(
        .SKIP_MEM (1'b0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_codes[$];
    logic [VW-1:0]    obs_v [MAXC];
    logic [TW-1:0]    obs_t [MAXC];
    logic [CNT_W-1:0] m_cyc = '0;
    logic [CNT_W-1:0] m_ret = '0;

    // Output vector: {IF,ID,EXE,MEM,WB, ir_we, pc_we, dm_we_en, rf_we_en, retire, halted}
    function automatic logic [VW-1:0] exp_vec(input int code, input bit last, input bit st);
        logic [VW-1:0] v;
        v = '0;
        if (code == int'(ST_HALT)) begin
            v[0] = 1'b1;
            return v;
        end
        v    = 11'b100_0000_0000 >> code;
        v[5] = (code == int'(ST_IF));
        v[4] = last;
        v[3] = last && st && (code == int'(ST_MEM));
        v[2] = (code == int'(ST_WB));
        v[1] = last;
        return v;
    endfunction

    function automatic logic [TW-1:0] exp_trace(input int i, input bit st,
                                                 input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] r0);
        int n;
        n = exp_codes.size();
        return {exp_vec(exp_codes[i], i == n - 1, st), DISP_W'(exp_codes[i]), c0 + CNT_W'(i), r0};
    endfunction

    function automatic logic [TW-1:0] halt_trace(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] r0);
        return {exp_vec(int'(ST_HALT), 1'b0, 1'b0), DISP_W'(int'(ST_HALT)), c0, r0};
    endfunction

    // Stage sequence of one instruction, straight from the class rules.
    function automatic void build_sched(input bit jbr, input bit rfw, input bit mem, input bit st,
                                        input int busy, input int wt);
        exp_codes.delete();
        exp_codes.push_back(int'(ST_IF));
        exp_codes.push_back(int'(ST_ID));
        if (jbr && !rfw) return;
        for (int k = 0; k <= busy; k++) exp_codes.push_back(int'(ST_EXE));
        if (mem) begin
            for (int k = 0; k <= wt; k++) exp_codes.push_back(int'(ST_MEM));
            if (!st) exp_codes.push_back(int'(ST_WB));
        end else if (rfw) begin
            exp_codes.push_back(int'(ST_MEM));
            exp_codes.push_back(int'(ST_WB));
        end
    endfunction

    task automatic capture(input int i);
        obs_v[i] = {bus.IF_valid, bus.ID_valid, bus.EXE_valid, bus.MEM_valid, bus.WB_valid,
                    bus.ir_we, bus.pc_we, bus.dm_we_en, bus.rf_we_en, bus.retire, bus.halted};
        obs_t[i] = {obs_v[i], bus.display_state, bus.cycle_cnt, bus.retire_cnt};
    endtask

    task automatic rand_inputs();
        bus.id_jbr    = 1'($urandom_range(0, 1));
        bus.id_rf_wen = 1'($urandom_range(0, 1));
        bus.id_mem_op = 1'($urandom_range(0, 1));
        bus.id_store  = 1'($urandom_range(0, 1));
        bus.exe_busy  = 1'($urandom_range(0, 1));
        bus.mem_ready = 1'($urandom_range(0, 1));
    endtask

    // Runs one instruction from its IF cycle; decode inputs are only valid in ID.
    task automatic drive_instr(input bit jbr, input bit rfw, input bit mem, input bit st,
                               input int busy, input int wt, output int n);
        int ei;
        int mi;
        ei = 0;
        mi = 0;
        build_sched(jbr, rfw, mem, st, busy, wt);
        n = exp_codes.size();
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            bus.step = 1'($urandom_range(0, 1));
            if (exp_codes[i] == int'(ST_ID)) begin
                bus.id_jbr    = jbr;
                bus.id_rf_wen = rfw;
                bus.id_mem_op = mem;
                bus.id_store  = st;
            end else if (exp_codes[i] == int'(ST_EXE)) begin
                bus.exe_busy = (ei < busy);
                ei++;
            end else if (exp_codes[i] == int'(ST_MEM) && mem) begin
                bus.mem_ready = (mi >= wt);
                mi++;
            end
            @(negedge clk);
            capture(i);
            @(posedge clk);
            #1;
        end
        bus.step = 1'b0;
    endtask

    task automatic drive_halt(input int n, input int step_at);
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            bus.step = (i == step_at);
            @(negedge clk);
            capture(i);
            @(posedge clk);
            #1;
        end
        bus.step = 1'b0;
    endtask

    task automatic test_reset();
        rand_inputs();
        bus.halt_req = 1'b1;
        bus.step     = 1'b1;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        capture(0);
        checks++;
        if (obs_t[0] !== '0) begin
            failures++;
            $display("FAIL reset_hold got=%h want=0", obs_t[0]);
        end
        bus.halt_req = 1'b0;
        bus.step     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cyc = '0;
        m_ret = '0;
    endtask

    task automatic test_alu();
        int n;
        logic [CNT_W-1:0] c0, r0;
        c0 = m_cyc;
        r0 = m_ret;
        drive_instr(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b0, c0, r0)) begin
                failures++;
                $display("FAIL alu cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b0, c0, r0));
            end
        end
        m_cyc = m_cyc + CNT_W'(n);
        m_ret = m_ret + CNT_W'(1);
        checks++;
        if (bus.cycle_cnt !== m_cyc || bus.retire_cnt !== m_ret) begin
            failures++;
            $display("FAIL alu_counters got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                     bus.cycle_cnt, bus.retire_cnt, m_cyc, m_ret);
        end
    endtask

    task automatic test_jump();
        int n;
        logic [CNT_W-1:0] c0, r0;
        c0 = m_cyc;
        r0 = m_ret;
        drive_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b0, c0, r0)) begin
                failures++;
                $display("FAIL jump cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b0, c0, r0));
            end
        end
        m_cyc = m_cyc + CNT_W'(n);
        m_ret = m_ret + CNT_W'(1);
        checks++;
        if (bus.IF_valid !== 1'b1 || bus.retire_cnt !== m_ret) begin
            failures++;
            $display("FAIL jump_next_if got if=%b ret=%0d want if=1 ret=%0d", bus.IF_valid, bus.retire_cnt, m_ret);
        end
    endtask

    task automatic test_store();
        int n;
        int dm;
        logic [CNT_W-1:0] c0, r0;
        c0 = m_cyc;
        r0 = m_ret;
        dm = 0;
        drive_instr(1'b0, 1'b0, 1'b1, 1'b1, 0, 2, n);
        for (int i = 0; i < n; i++) begin
            dm += int'(obs_v[i][3]);
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b1, c0, r0)) begin
                failures++;
                $display("FAIL store cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b1, c0, r0));
            end
        end
        checks++;
        if (dm != 1) begin
            failures++;
            $display("FAIL store_write_count got=%0d want=1", dm);
        end
        m_cyc = m_cyc + CNT_W'(n);
        m_ret = m_ret + CNT_W'(1);
    endtask

    task automatic test_load();
        int n;
        logic [CNT_W-1:0] c0, r0;
        c0 = m_cyc;
        r0 = m_ret;
        drive_instr(1'b0, 1'b1, 1'b1, 1'b0, 3, 0, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b0, c0, r0)) begin
                failures++;
                $display("FAIL load cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b0, c0, r0));
            end
        end
        m_cyc = m_cyc + CNT_W'(n);
        m_ret = m_ret + CNT_W'(1);
    endtask

    task automatic test_random();
        int n, cls, busy, wt;
        bit jbr, rfw, mem, st;
        logic [CNT_W-1:0] c0, r0;
        for (int k = 0; k < 40; k++) begin
            cls  = int'($urandom_range(0, 5));
            busy = int'($urandom_range(0, 3));
            wt   = int'($urandom_range(0, 3));
            st   = 1'($urandom_range(0, 1));
            case (cls)
                0:       begin jbr = 1'b0; rfw = 1'b1; mem = 1'b0; end
                1:       begin jbr = 1'b1; rfw = 1'b0; mem = 1'b0; end
                2:       begin jbr = 1'b1; rfw = 1'b1; mem = 1'b0; end
                3:       begin jbr = 1'b0; rfw = 1'b0; mem = 1'b0; end
                4:       begin jbr = 1'b0; rfw = 1'b1; mem = 1'b1; st = 1'b0; end
                default: begin jbr = 1'b0; rfw = 1'b0; mem = 1'b1; st = 1'b1; end
            endcase
            c0 = m_cyc;
            r0 = m_ret;
            drive_instr(jbr, rfw, mem, st, busy, wt, n);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs_t[i] !== exp_trace(i, mem && st, c0, r0)) begin
                    failures++;
                    $display("FAIL random op%0d class%0d cycle%0d got=%h want=%h",
                             k, cls, i + 1, obs_t[i], exp_trace(i, mem && st, c0, r0));
                end
            end
            m_cyc = m_cyc + CNT_W'(n);
            m_ret = m_ret + CNT_W'(1);
        end
    endtask

    task automatic test_halt_step();
        int n;
        logic [CNT_W-1:0] c0, r0;
        bus.halt_req = 1'b1;
        c0 = m_cyc;
        r0 = m_ret;
        drive_instr(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b0, c0, r0)) begin
                failures++;
                $display("FAIL halt_alu cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b0, c0, r0));
            end
        end
        m_cyc = m_cyc + CNT_W'(n);
        m_ret = m_ret + CNT_W'(1);

        drive_halt(4, 3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_t[i] !== halt_trace(m_cyc, m_ret)) begin
                failures++;
                $display("FAIL halt_hold cycle%0d got=%h want=%h", i + 1, obs_t[i], halt_trace(m_cyc, m_ret));
            end
        end

        c0 = m_cyc;
        r0 = m_ret;
        drive_instr(1'b0, 1'b1, 1'b1, 1'b0, 1, 1, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b0, c0, r0)) begin
                failures++;
                $display("FAIL step_instr cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b0, c0, r0));
            end
        end
        m_cyc = m_cyc + CNT_W'(n);
        m_ret = m_ret + CNT_W'(1);

        drive_halt(2, -1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_t[i] !== halt_trace(m_cyc, m_ret)) begin
                failures++;
                $display("FAIL rehalt cycle%0d got=%h want=%h", i + 1, obs_t[i], halt_trace(m_cyc, m_ret));
            end
        end

        bus.halt_req = 1'b0;
        drive_halt(1, -1);
        checks++;
        if (obs_t[0] !== halt_trace(m_cyc, m_ret)) begin
            failures++;
            $display("FAIL unhalt got=%h want=%h", obs_t[0], halt_trace(m_cyc, m_ret));
        end

        c0 = m_cyc;
        r0 = m_ret;
        drive_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b0, c0, r0)) begin
                failures++;
                $display("FAIL resume cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b0, c0, r0));
            end
        end
        m_cyc = m_cyc + CNT_W'(n);
        m_ret = m_ret + CNT_W'(1);
    endtask

    task automatic test_reset_mid();
        int n;
        bus.id_jbr    = 1'b0;
        bus.id_rf_wen = 1'b1;
        bus.id_mem_op = 1'b0;
        bus.id_store  = 1'b0;
        bus.exe_busy  = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.EXE_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_in_exe got=%b want=1", bus.EXE_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        capture(0);
        checks++;
        if (obs_t[0] !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%h want=0", obs_t[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cyc = '0;
        m_ret = '0;
        drive_instr(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_t[i] !== exp_trace(i, 1'b0, '0, '0)) begin
                failures++;
                $display("FAIL reset_mid_alu cycle%0d got=%h want=%h", i + 1, obs_t[i], exp_trace(i, 1'b0, '0, '0));
            end
        end
    endtask

    initial begin
        bus.halt_req = 1'b0;
        bus.step     = 1'b0;
        rand_inputs();
        test_reset();
        test_alu();
        test_jump();
        test_store();
        test_load();
        test_random();
        test_halt_step();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
